// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: walks a ROM register table and programs the camera sensor through the 24-bit i2c transmitter.
// Define CFG_TIMEOUT_EN to bound the wait for done; an expired wait is handled as a NACK.
module cam_cfg_sequencer #(
  parameter logic [7:0] DEV_ADDR = 8'h42,
  parameter int ADDR_W = 8,
  parameter int DELAY_CYCLES = 250000,
  parameter int MAX_RETRY = 3
`ifdef CFG_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic              meg25,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [23:0]       send_dat,
  output logic              sendit,
  input  logic              done,
  input  logic              ack,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [ADDR_W:0]   entries_written
);
  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, SEND = 4'd3, WAIT_DONE = 4'd4,
                         RELEASE = 4'd5, DELAY = 4'd6, FINISH = 4'd7, ERROR = 4'd8;
  localparam int DW = $clog2(DELAY_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [3:0] state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [23:0] send_dat_q, send_dat_d;
  logic busy_q, busy_d, cfg_done_q, cfg_done_d, cfg_error_q, cfg_error_d;
  logic [ADDR_W:0] entries_q, entries_d;
  logic [RW-1:0] retry_q, retry_d;
  logic ack_s_q, ack_s_d;
  logic [DW-1:0] delay_q, delay_d;
  logic last_addr, tmo_hit;
  assign last_addr = &rom_addr_q;
  assign sendit = (state_q == SEND) || (state_q == WAIT_DONE);
  assign rom_addr = rom_addr_q;
  assign send_dat = send_dat_q;
  assign busy = busy_q;
  assign cfg_done = cfg_done_q;
  assign cfg_error = cfg_error_q;
  assign entries_written = entries_q;
`ifdef CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  // Counts from the sendit rise, so the SEND cycle is part of the budget.
  assign tmo_hit = (state_q == WAIT_DONE) && (tmo_q >= TW'(TIMEOUT_CYCLES - 1));
  always_comb tmo_d = sendit ? tmo_q + 1'b1 : '0;
  always_ff @(posedge meg25) begin
    if (rst) tmo_q <= '0;
    else tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rom_addr_d = rom_addr_q;
    send_dat_d = send_dat_q;
    busy_d = busy_q;
    cfg_done_d = cfg_done_q;
    cfg_error_d = cfg_error_q;
    entries_d = entries_q;
    retry_d = retry_q;
    ack_s_d = ack_s_q;
    delay_d = delay_q;
    case (state_q)
      IDLE: if (start) begin
        cfg_done_d = 1'b0;
        cfg_error_d = 1'b0;
        entries_d = '0;
        rom_addr_d = '0;
        retry_d = '0;
        busy_d = 1'b1;
        state_d = FETCH;
      end
      FETCH: state_d = DECODE;
      DECODE: if (rom_data == 16'hFFFF) state_d = FINISH;
        else if (rom_data == 16'hFFF0) begin
          delay_d = DW'(DELAY_CYCLES - 1);
          state_d = DELAY;
        end else begin
          send_dat_d = {DEV_ADDR, rom_data};
          state_d = SEND;
        end
      SEND: state_d = WAIT_DONE;
      WAIT_DONE: if (done || tmo_hit) begin
        ack_s_d = done & ack;
        state_d = RELEASE;
      end
      RELEASE: if (!done) begin
        if (ack_s_q) begin
          entries_d = entries_q + 1'b1;
          retry_d = '0;
          rom_addr_d = last_addr ? rom_addr_q : rom_addr_q + 1'b1;
          state_d = last_addr ? ERROR : FETCH;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = SEND;
        end else state_d = ERROR;
      end
      DELAY: if (delay_q == '0) begin
        rom_addr_d = last_addr ? rom_addr_q : rom_addr_q + 1'b1;
        state_d = last_addr ? ERROR : FETCH;
      end else delay_d = delay_q - 1'b1;
      FINISH: begin
        busy_d = 1'b0;
        cfg_done_d = 1'b1;
        state_d = IDLE;
      end
      ERROR: begin
        busy_d = 1'b0;
        cfg_error_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge meg25) begin
    if (rst) begin
      state_q <= IDLE;
      rom_addr_q <= '0;
      send_dat_q <= '0;
      busy_q <= 1'b0;
      cfg_done_q <= 1'b0;
      cfg_error_q <= 1'b0;
      entries_q <= '0;
      retry_q <= '0;
      ack_s_q <= 1'b0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      rom_addr_q <= rom_addr_d;
      send_dat_q <= send_dat_d;
      busy_q <= busy_d;
      cfg_done_q <= cfg_done_d;
      cfg_error_q <= cfg_error_d;
      entries_q <= entries_d;
      retry_q <= retry_d;
      ack_s_q <= ack_s_d;
      delay_q <= delay_d;
    end
  end
endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// tb_cam_cfg_sequencer: scoreboard bench for cam_cfg_sequencer with a ROM model, an i2c responder and a table-walking reference model.
`timescale 1ns/1ps
module tb_cam_cfg_sequencer;
  localparam int AW = 4, DLY = 100, MR = 3, N = 1 << AW;
`ifdef CFG_TIMEOUT_EN
  localparam int TO = 64;
`endif
  typedef struct { logic [23:0] dat; int gap; } tx_t;
  typedef struct { bit dn; bit er; int ent; int addr; } res_t;
  logic meg25 = 0, rst = 1, start = 0, done = 0, ack = 0;
  logic [AW-1:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic [23:0] send_dat;
  logic sendit, busy, cfg_done, cfg_error;
  logic [AW:0] entries_written;
  logic [15:0] rom [N];
  int nack [N];
  tx_t exp_q[$];
  res_t res_q[$];
  bit ack_q[$];
  bit mute = 0, hold_off = 0;
  int vectors = 0, miscompares = 0, passes = 0;

  cam_cfg_sequencer #(.DEV_ADDR(8'h42), .ADDR_W(AW), .DELAY_CYCLES(DLY), .MAX_RETRY(MR)
`ifdef CFG_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .meg25(meg25), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .send_dat(send_dat), .sendit(sendit), .done(done), .ack(ack), .busy(busy),
    .cfg_done(cfg_done), .cfg_error(cfg_error), .entries_written(entries_written)
  );

  always #20 meg25 = ~meg25;
  always @(posedge meg25) rom_data <= rom[rom_addr];

  task automatic chk(input string n, input bit ok, input longint act, input longint req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h required 'h%0h at %0t", n, act, req, $time);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Reference model: walk the table as the rules describe and list every transaction plus the pass outcome.
  task automatic build_expect();
    int gap = 1, ent = 0, tries;
    res_t r;
    tx_t t;
    ack_q.delete();
    r.dn = 0; r.er = 1; r.addr = N - 1;
    for (int i = 0; i < N; i++) begin
      if (rom[i] == 16'hFFFF) begin r.dn = 1; r.er = 0; r.addr = i; break; end
      if (rom[i] == 16'hFFF0) begin gap += DLY; continue; end
      tries = (nack[i] > MR) ? MR + 1 : nack[i] + 1;
      for (int a = 0; a < tries; a++) begin
        t.dat = {8'h42, rom[i]}; t.gap = gap; gap = 1;
        exp_q.push_back(t);
        if (!mute) ack_q.push_back(a >= nack[i]);
      end
      if (nack[i] > MR) begin r.addr = i; break; end
      ent++;
    end
    r.ent = ent;
    res_q.push_back(r);
  endtask

  function automatic logic [15:0] rand_dat();
    logic [15:0] v = 16'($urandom);
    if (v[15:4] == 12'hFFF) v[15] = 1'b0;
    return v;
  endfunction

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    for (int i = 0; i < N; i++) begin rom[i] = rand_dat(); nack[i] = 0; end
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic rand_rom();
    int len = ($urandom_range(0, 9) == 0) ? N : $urandom_range(0, N - 2);
    int r;
    for (int i = 0; i < N; i++) begin
      rom[i] = (i == len) ? 16'hFFFF : ($urandom_range(0, 7) == 0 ? 16'hFFF0 : rand_dat());
      r = $urandom_range(0, 11);
      nack[i] = (r < 8) ? 0 : (r < 11) ? $urandom_range(1, MR) : MR + 1;
    end
  endtask

  task automatic run_pass();
    int target = passes + 1;
    build_expect();
    @(negedge meg25); start = 1;
    @(negedge meg25); start = 0;
    @(negedge meg25); start = 1;
    @(negedge meg25); start = 0;
    for (int c = 0; c < 6000 && passes < target; c++) @(negedge meg25);
    if (passes < target) begin
      chk("pass_timeout", 0, passes, target);
      summary();
    end
    repeat ($urandom_range(1, 4)) @(negedge meg25);
  endtask

  // i2c responder: done after a random latency, held until sendit drops, then released at random.
  initial begin
    int wait_n = -1;
    forever begin
      @(negedge meg25);
      if (rst) begin done = 0; wait_n = -1; ack_q.delete(); end
      else if (done) begin
        if (!sendit && $urandom_range(0, 1) == 1) done = 0;
      end else if (sendit && !mute) begin
        if (wait_n < 0) wait_n = hold_off ? 40 : $urandom_range(0, 5);
        if (wait_n == 0) begin
          done = 1;
          ack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b1;
          wait_n = -1;
        end else wait_n--;
      end
    end
  end

  initial begin
    bit ps = 0, pb = 0;
    int lo = 0, hi = 0;
    tx_t cur;
    res_t r;
    cur.dat = '0; cur.gap = 0;
    forever begin
      @(posedge meg25); #1;
      if (rst) begin
        exp_q.delete(); res_q.delete(); ps = 0; pb = 0; lo = 0; hi = 0;
      end else begin
        if (sendit && !ps) begin
          if (exp_q.size() == 0) chk("unexpected_tx", 0, send_dat, 0);
          else begin
            cur = exp_q.pop_front();
            chk("tx_dat", send_dat == cur.dat, send_dat, cur.dat);
            chk("tx_gap", lo >= cur.gap, lo, cur.gap);
          end
          hi = 0;
        end
        if (!sendit && ps) begin
          chk("dat_hold", send_dat == cur.dat, send_dat, cur.dat);
`ifdef CFG_TIMEOUT_EN
          if (mute) chk("hi_cycles", hi == TO, hi, TO); else
`endif
          chk("held_until_done", done == 1'b1, done, 1);
        end
        if (sendit) begin hi++; lo = 0; end else lo++;
        if (!busy && pb) begin
          chk("tx_left", exp_q.size() == 0, exp_q.size(), 0);
          if (res_q.size() == 0) chk("unexpected_end", 0, busy, 1);
          else begin
            r = res_q.pop_front();
            chk("cfg_done", cfg_done == r.dn, cfg_done, r.dn);
            chk("cfg_error", cfg_error == r.er, cfg_error, r.er);
            chk("entries_written", entries_written == (AW+1)'(r.ent), entries_written, r.ent);
            chk("rom_addr", rom_addr == AW'(r.addr), rom_addr, r.addr);
          end
          passes++;
        end
        ps = sendit; pb = busy;
      end
    end
  end

  initial begin
    load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge meg25);
    chk("rst_sendit", sendit == 0, sendit, 0);
    chk("rst_busy", busy == 0, busy, 0);
    chk("rst_cfg_done", cfg_done == 0, cfg_done, 0);
    chk("rst_cfg_error", cfg_error == 0, cfg_error, 0);
    chk("rst_entries", entries_written == 0, entries_written, 0);
    chk("rst_rom_addr", rom_addr == 0, rom_addr, 0);
    rst = 0;
    repeat (2) @(negedge meg25);
    load(16'h1280, 16'h1214, 16'hFFFF, 16'h0000); run_pass();
    load(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF); run_pass();
    load(16'h1280, 16'h1214, 16'hFFFF, 16'h0000); nack[1] = 1; run_pass();
    load(16'h1280, 16'h1214, 16'hFFFF, 16'h0000); nack[1] = MR + 1; run_pass();
    load(16'hFFFF, 16'h1280, 16'h1214, 16'h0000); run_pass();
    load(16'h1280, 16'h1214, 16'h1380, 16'h1400); run_pass();
    // Reset while the transmitter is still busy with the first entry.
    load(16'h1280, 16'h1214, 16'hFFFF, 16'h0000);
    hold_off = 1;
    build_expect();
    @(negedge meg25); start = 1;
    @(negedge meg25); start = 0;
    for (int c = 0; c < 50 && !sendit; c++) @(negedge meg25);
    chk("reset_test_sendit_seen", sendit == 1, sendit, 1);
    repeat (3) @(negedge meg25);
    rst = 1;
    @(posedge meg25); #2;
    chk("midrst_sendit", sendit == 0, sendit, 0);
    chk("midrst_busy", busy == 0, busy, 0);
    chk("midrst_cfg_done", cfg_done == 0, cfg_done, 0);
    chk("midrst_cfg_error", cfg_error == 0, cfg_error, 0);
    chk("midrst_entries", entries_written == 0, entries_written, 0);
    @(negedge meg25); rst = 0; hold_off = 0;
    repeat (2) @(negedge meg25);
    load(16'h1280, 16'h1214, 16'hFFFF, 16'h0000); run_pass();
`ifdef CFG_TIMEOUT_EN
    mute = 1;
    load(16'h1280, 16'h1214, 16'hFFFF, 16'h0000); nack[0] = MR + 1; run_pass();
    mute = 0;
`endif
    for (int p = 0; p < 20; p++) begin
      rand_rom();
      run_pass();
    end
    summary();
  end
endmodule

// File: doc/cam_cfg_sequencer.md
Name: cam_cfg_sequencer

Overview:
- Walks a register table in ROM and programs the camera sensor over SCCB/I2C.
- Drives the existing 24-bit i2c transmitter through its send_dat/sendit/done/ack handshake, one table entry per transaction.
- Sits between power-up/reset logic and the i2c block; reports busy, done and error to the VGA/camera top level.

Parameters:
- DEV_ADDR, 8'h42, 8-bit device write address placed in send_dat[23:16].
- ADDR_W, 8, ROM address width; table holds up to 2**ADDR_W entries.
- DELAY_CYCLES, 250000, meg25 cycles waited for a delay entry (10 ms at 25 MHz).
- MAX_RETRY, 3, re-sends of one entry after NACK before error.
- TIMEOUT_CYCLES, 4096, meg25 cycles allowed from sendit rise to done (CFG_TIMEOUT_EN only).

Ports:
- meg25  in  1  system clock (25 MHz).
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse or level; begins a configuration pass when idle.
- rom_addr  out  ADDR_W  table read address.
- rom_data  in  16  table entry {reg[15:8], val[7:0]}, valid 1 cycle after rom_addr.
- send_dat  out  24  {DEV_ADDR, reg, val} to i2c.
- sendit  out  1  transaction request to i2c (level).
- done  in  1  i2c transaction complete (level, high until sendit drops).
- ack  in  1  sampled with done; 1 = all bytes acknowledged, 0 = NACK.
- busy  out  1  pass in progress.
- cfg_done  out  1  sticky: pass finished cleanly.
- cfg_error  out  1  sticky: pass aborted.
- entries_written  out  ADDR_W+1  count of acknowledged writes this pass.

Behaviour:
- Reset: all outputs 0; state IDLE; retry, delay and timeout counters 0.
- Reset mid-operation: sendit drops the same cycle; the FSM does not wait for done.
- States: IDLE, FETCH, DECODE, SEND, WAIT_DONE, RELEASE, DELAY, FINISH, ERROR.
- IDLE: on start=1, clear cfg_done, cfg_error, entries_written and rom_addr, set busy, go to FETCH. start is ignored in every other state.
- FETCH: 1 cycle for ROM latency, then DECODE.
- DECODE:
  - rom_data==16'hFFFF: end marker, go to FINISH.
  - rom_data==16'hFFF0: delay entry, load the delay counter, go to DELAY.
  - Otherwise: latch send_dat={DEV_ADDR,rom_data}, go to SEND.
- SEND: assert sendit; go to WAIT_DONE next cycle. send_dat is stable from SEND until RELEASE exits.
- WAIT_DONE: hold sendit=1 until done=1. On that cycle sample ack, drop sendit, go to RELEASE.
- RELEASE: wait for done=0, then act on the sampled ack:
  - ack=1: increment entries_written and rom_addr, clear the retry count, go to FETCH.
  - ack=0 and retry<MAX_RETRY: increment retry, go to SEND with the same data.
  - ack=0 and retry==MAX_RETRY: go to ERROR.
- Latency: a minimum of 1 idle cycle with sendit=0 between transactions.
- DELAY: count DELAY_CYCLES-1 down to 0, then increment rom_addr and go to FETCH. rom_addr is not incremented for the end marker.
- Address wrap: if rom_addr would wrap past 2**ADDR_W-1 with no end marker, go to ERROR.
- FINISH: busy=0, cfg_done=1, go to IDLE.
- ERROR: busy=0, cfg_error=1, go to IDLE. rom_addr holds the failing entry until the next start.
- cfg_done and cfg_error are never both 1.
- If done=1 while in SEND (stale from i2c), it is not consumed; WAIT_DONE is still entered.

Optional Feature:
- Macro: CFG_TIMEOUT_EN.
- Defined: a counter runs in WAIT_DONE. Reaching TIMEOUT_CYCLES drops sendit and is treated as NACK, so the retry path applies; RELEASE still waits for done=0.
- Not defined: WAIT_DONE waits indefinitely; no counter logic is synthesized.

Test Plan:
- Clean pass: ROM {1280, 1214, FFFF}, i2c model acks all. Required: 2 transactions with send_dat 421280 then 421214, each sendit held until done; cfg_done=1, entries_written=2, busy=0.
- Delay entry: ROM {1280, FFF0, 1101, FFFF}, DELAY_CYCLES=100. Required: sendit for 421101 rises no earlier than 100 cycles after the first RELEASE exits; cfg_done=1.
- Single NACK then recovery: first attempt on 421214 returns ack=0, second returns ack=1. Required: send_dat unchanged across the re-send; entries_written=2 at finish; cfg_error=0.
- Persistent NACK, MAX_RETRY=3: Required: exactly 4 sendit pulses for the entry; cfg_error=1; rom_addr points at the entry; a new start restarts from address 0.
- Reset mid-transaction: rst=1 during WAIT_DONE. Required: next cycle sendit=0, busy=0, cfg_done=0, cfg_error=0, entries_written=0.
- Timeout (CFG_TIMEOUT_EN, TIMEOUT_CYCLES=64): i2c model never raises done. Required: sendit drops 64 cycles after it rises; retried 3 times; cfg_error=1.
